// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a register busy scoreboard and an ID/EX pipeline register.
// Optional macro ID_BYPASS_EN: forward same-cycle writeback data into the latched operands and skip that stall.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rs1_src,
  output logic [4:0]      rs2_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd_src,
  input  logic [XLEN-1:0] wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd_src,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_reg_we,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic logic [NREG-1:0] onehot(input logic [4:0] idx);
    logic [NREG-1:0] v;
    v = {NREG{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] build_imm(input imm_fmt_e fmt, input logic [31:0] ins);
    logic [XLEN-1:0] v;
    case (fmt)
      IMM_I:   v = {{(XLEN-12){ins[31]}}, ins[31:20]};
      IMM_S:   v = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   v = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
      IMM_J:   v = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = {XLEN{1'b0}};
    endcase
    return v;
  endfunction

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            wr_op;
  logic            legal;
  imm_fmt_e        imm_fmt;
  logic            writes_rd;
  logic [XLEN-1:0] imm;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] flush_clr;
  logic [NREG-1:0] set_mask;
  logic            hazard;
  logic            stall;
  logic            accept;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign opcode  = in_instr[6:0];
  assign rd      = in_instr[11:7];
  assign rs1_src = in_instr[19:15];
  assign rs2_src = in_instr[24:20];

  // Operand usage, destination write and immediate format per opcode; unknown opcodes are illegal.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    wr_op    = 1'b0;
    legal    = 1'b1;
    imm_fmt  = IMM_NONE;
    case (opcode)
      OPC_LUI:    begin wr_op = 1'b1; imm_fmt = IMM_U; end
      OPC_AUIPC:  begin wr_op = 1'b1; imm_fmt = IMM_U; end
      OPC_JAL:    begin wr_op = 1'b1; imm_fmt = IMM_J; end
      OPC_JALR:   begin uses_rs1 = 1'b1; wr_op = 1'b1; imm_fmt = IMM_I; end
      OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_fmt = IMM_B; end
      OPC_LOAD:   begin uses_rs1 = 1'b1; wr_op = 1'b1; imm_fmt = IMM_I; end
      OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_fmt = IMM_S; end
      OPC_OPIMM:  begin uses_rs1 = 1'b1; wr_op = 1'b1; imm_fmt = IMM_I; end
      OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; wr_op = 1'b1; end
      OPC_MISC:   begin legal = 1'b1; end
      OPC_SYSTEM: begin legal = 1'b1; end
      default:    begin legal = 1'b0; end
    endcase
  end

  assign writes_rd = wr_op && (rd != 5'd0);
  assign imm       = build_imm(imm_fmt, in_instr);

  assign wb_clr    = (wb_we && (wb_rd_src != 5'd0)) ? onehot(wb_rd_src) : {NREG{1'b0}};
  assign flush_clr = (flush && out_valid && out_reg_we) ? onehot(out_rd_src) : {NREG{1'b0}};

`ifdef ID_BYPASS_EN
  // A register whose writer retires this cycle is forwarded, so it no longer blocks issue.
  assign eff_busy = busy & ~wb_clr;
  assign op1 = (wb_we && (wb_rd_src != 5'd0) && (wb_rd_src == rs1_src)) ? wb_rd : rs1;
  assign op2 = (wb_we && (wb_rd_src != 5'd0) && (wb_rd_src == rs2_src)) ? wb_rd : rs2;
`else
  // The regfile write lands at the edge, so a retiring register still blocks issue this cycle.
  logic unused_wb_rd;
  assign eff_busy     = busy;
  assign op1          = rs1;
  assign op2          = rs2;
  assign unused_wb_rd = ^wb_rd;
`endif

  assign hazard   = (uses_rs1 && eff_busy[rs1_src])
                 || (uses_rs2 && eff_busy[rs2_src])
                 || (writes_rd && eff_busy[rd]);
  assign stall    = in_valid && hazard;
  assign in_ready = !rst && !flush && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign set_mask = (accept && writes_rd) ? onehot(rd) : {NREG{1'b0}};

  // Scoreboard update: writeback and flush clear, a new writer sets; set wins on the same index.
  always_comb begin
    busy_next    = (busy & ~wb_clr & ~flush_clr) | set_mask;
    busy_next[0] = 1'b0;
  end

  // ID/EX pipeline register and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= {NREG{1'b0}};
      out_valid    <= 1'b0;
      out_pc       <= 32'd0;
      out_rs1_val  <= {XLEN{1'b0}};
      out_rs2_val  <= {XLEN{1'b0}};
      out_imm      <= {XLEN{1'b0}};
      out_rd_src   <= 5'd0;
      out_opcode   <= 7'd0;
      out_funct3   <= 3'd0;
      out_funct7b5 <= 1'b0;
      out_reg_we   <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_rs1_val  <= op1;
        out_rs2_val  <= op2;
        out_imm      <= imm;
        out_rd_src   <= rd;
        out_opcode   <= opcode;
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_reg_we   <= writes_rd;
        out_illegal  <= !legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes expected ID/EX contents, a negedge monitor pops on each consume.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [4:0]  rs1_src;
  logic [4:0]  rs2_src;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        wb_we;
  logic [4:0]  wb_rd_src;
  logic [31:0] wb_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd_src;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_reg_we;
  logic        out_illegal;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .rs1_src(rs1_src), .rs2_src(rs2_src), .rs1(rs1), .rs2(rs2),
    .wb_we(wb_we), .wb_rd_src(wb_rd_src), .wb_rd(wb_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd_src(out_rd_src), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_reg_we(out_reg_we), .out_illegal(out_illegal)
  );

  logic [31:0] regs [32];
  assign rs1 = regs[rs1_src];
  assign rs2 = regs[rs2_src];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                              input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7, input logic we, input logic ill);
    exp_t e;
    e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = rd;
    e.op = op; e.f3 = f3; e.f7 = f7; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every consumed ID/EX entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got out_pc=%h required no output", out_pc);
      end else begin
        me = q.pop_front();
        check("out_pc", out_pc, me.pc);
        check("out_rs1_val", out_rs1_val, me.r1);
        check("out_rs2_val", out_rs2_val, me.r2);
        check("out_imm", out_imm, me.imm);
        check("out_rd_src", 32'(out_rd_src), 32'(me.rd));
        check("out_opcode", 32'(out_opcode), 32'(me.op));
        check("out_funct3", 32'(out_funct3), 32'(me.f3));
        check("out_funct7b5", 32'(out_funct7b5), 32'(me.f7));
        check("out_reg_we", 32'(out_reg_we), 32'(me.we));
        check("out_illegal", 32'(out_illegal), 32'(me.ill));
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input exp_t e,
                      input bit push, output int waited);
    in_valid = 1'b1; in_pc = pc; in_instr = instr; waited = 0;
    @(negedge clk);
    check("rs1_src", 32'(rs1_src), 32'(instr[19:15]));
    check("rs2_src", 32'(rs2_src), 32'(instr[24:20]));
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      if (push) q.push_back(e);
    end else begin
      check("send_accept_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic hazard(input string nm, input logic [31:0] pc, input logic [31:0] instr, input exp_t e,
                        input logic [4:0] wsrc, input logic [31:0] wdata, input int wcyc);
    int  acc;
    bit  acc_now;
`ifdef ID_BYPASS_EN
    acc = wcyc;
`else
    acc = wcyc + 1;
`endif
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
    for (int c = 1; c <= acc; c++) begin
      wb_we = (c == wcyc); wb_rd_src = wsrc; wb_rd = wdata;
      @(negedge clk);
      check($sformatf("%s_ready_c%0d", nm, c), 32'(in_ready), 32'(c == acc));
      acc_now = in_ready;
      if (acc_now) q.push_back(e);
      @(posedge clk); #1;
      if (wb_we) regs[wsrc] = wdata;
      wb_we = 1'b0;
      if (acc_now) break;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int w;
    exp_t none;
    none = '0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000 + 32'(i) * 32'h111;
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'hFFD00293;
    out_ready = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd_src = 5'd0; wb_rd = 32'h0;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_rd_src", 32'(out_rd_src), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // ADDI x5,x0,-3 then one-cycle latency to out_valid
    send(32'h100, 32'hFFD00293, mk(32'h100, 32'h0, regs[29], 32'hFFFFFFFD, 5'd5, 7'h13, 3'd0, 1'b1, 1'b1, 1'b0), 1'b1, w);
    @(negedge clk);
    check("addi_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // RAW: ADD x6,x5,x5 waits for writeback of x5
    hazard("raw", 32'h104, 32'h00528333,
           mk(32'h104, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0),
           5'd5, 32'hFFFFFFFD, 3);
    @(posedge clk); #1;

    // Back-pressure: ADDI x9 held for 4 cycles while LUI x11 waits
    out_ready = 1'b0;
    send(32'h108, 32'h01200493, mk(32'h108, 32'h0, regs[18], 32'h12, 5'd9, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0), 1'b1, w);
    in_valid = 1'b1; in_pc = 32'h10C; in_instr = 32'hABCDE5B7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_pc", out_pc, 32'h108);
      check("bp_out_imm", out_imm, 32'h12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    if (in_ready) q.push_back(mk(32'h10C, regs[27], regs[28], 32'hABCDE000, 5'd11, 7'h37, 3'd6, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_loaded", out_pc, 32'h10C);
    @(posedge clk); #1;

    // Flush: held ADDI x7 dropped, busy[7] released, ADD x8,x7,x0 issues at once
    out_ready = 1'b0;
    send(32'h110, 32'h00100393, none, 1'b0, w);
    in_valid = 1'b1; in_pc = 32'h114; in_instr = 32'h00038433; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_held_rd", 32'(out_rd_src), 32'd7);
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy_released", 32'(in_ready), 32'd1);
    if (in_ready) q.push_back(mk(32'h114, regs[7], 32'h0, 32'h0, 5'd8, 7'h33, 3'd0, 1'b0, 1'b1, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Back-to-back independent instructions: illegal, x0 writes, S/B/J/I/U immediates
    send(32'h120, 32'h00000000, mk(32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1), 1'b1, w);
    check("tbl_illegal0_nostall", 32'(w), 32'd0);
    send(32'h124, 32'h00000F80, mk(32'h124, 32'h0, 32'h0, 32'h0, 5'd31, 7'h00, 3'd0, 1'b0, 1'b0, 1'b1), 1'b1, w);
    check("tbl_illegal31_nostall", 32'(w), 32'd0);
    send(32'h128, 32'h000F8693, mk(32'h128, regs[31], 32'h0, 32'h0, 5'd13, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0), 1'b1, w);
    check("tbl_x31_not_busy", 32'(w), 32'd0);
    send(32'h12C, 32'h12345037, mk(32'h12C, regs[8], regs[3], 32'h12345000, 5'd0, 7'h37, 3'd5, 1'b0, 1'b0, 1'b0), 1'b1, w);
    check("tbl_lui_x0_nostall", 32'(w), 32'd0);
    send(32'h130, 32'hFE20AE23, mk(32'h130, regs[1], regs[2], 32'hFFFFFFFC, 5'd28, 7'h23, 3'd2, 1'b1, 1'b0, 1'b0), 1'b1, w);
    check("tbl_sw_nostall", 32'(w), 32'd0);
    send(32'h134, 32'hFE208CE3, mk(32'h134, regs[1], regs[2], 32'hFFFFFFF8, 5'd25, 7'h63, 3'd0, 1'b1, 1'b0, 1'b0), 1'b1, w);
    check("tbl_beq_nostall", 32'(w), 32'd0);
    send(32'h138, 32'hFFDFF1EF, mk(32'h138, regs[31], regs[29], 32'hFFFFFFFC, 5'd3, 7'h6F, 3'd7, 1'b1, 1'b1, 1'b0), 1'b1, w);
    check("tbl_jal_nostall", 32'(w), 32'd0);
    send(32'h13C, 32'h01008267, mk(32'h13C, regs[1], regs[16], 32'h10, 5'd4, 7'h67, 3'd0, 1'b0, 1'b1, 1'b0), 1'b1, w);
    check("tbl_jalr_nostall", 32'(w), 32'd0);
    send(32'h140, 32'hFFFFF717, mk(32'h140, regs[31], regs[31], 32'hFFFFF000, 5'd14, 7'h17, 3'd7, 1'b1, 1'b1, 1'b0), 1'b1, w);
    check("tbl_auipc_nostall", 32'(w), 32'd0);

    // WAW: ADDI x3,x0,5 waits for the JAL x3 writeback
    hazard("waw", 32'h144, 32'h00500193,
           mk(32'h144, 32'h0, regs[5], 32'h5, 5'd3, 7'h13, 3'd0, 1'b0, 1'b1, 1'b0),
           5'd3, 32'h0000013C, 2);

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage; sits directly upstream of regfile and downstream of fetch.
- Takes instructions from fetch with a valid/ready handshake and drives the regfile read addresses combinationally.
- Extracts immediate and control fields, and latches operands into the ID/EX pipeline register with a valid/ready handshake to execute.
- Keeps a 32-entry busy scoreboard and stalls on RAW/WAW hazards against in-flight writers.

Parameters:
- XLEN, 32, data/immediate width.
- NREG, 32, register count; scoreboard width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  32  instruction PC.
- in_instr  in  32  instruction word.
- rs1_src  out  5  regfile read address; always equals in_instr[19:15].
- rs2_src  out  5  regfile read address; always equals in_instr[24:20].
- rs1  in  32  regfile read data for rs1_src (combinational).
- rs2  in  32  regfile read data for rs2_src (combinational).
- wb_we  in  1  writeback writes regfile this cycle.
- wb_rd_src  in  5  writeback destination.
- wb_rd  in  32  writeback data.
- flush  in  1  discard held and incoming instruction (taken branch/jump).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute consumes this cycle.
- out_pc  out  32  registered PC.
- out_rs1_val  out  32  registered rs1 operand.
- out_rs2_val  out  32  registered rs2 operand.
- out_imm  out  32  registered sign-extended immediate.
- out_rd_src  out  5  registered destination.
- out_opcode  out  7  registered instr[6:0].
- out_funct3  out  3  registered instr[14:12].
- out_funct7b5  out  1  registered instr[30].
- out_reg_we  out  1  instruction writes rd; 0 when rd==0.
- out_illegal  out  1  opcode not in RV32I base set.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, busy bitmap cleared, all out_* data fields 0.
- Decode (combinational on in_instr):
  - uses_rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2: BRANCH, STORE, OP.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and rd!=0.
- Immediate formats, sign-extended from bit 31:
  - I: JALR, LOAD, OP-IMM.
  - S: STORE.
  - B: BRANCH; bit 0 = 0.
  - U: LUI, AUIPC; low 12 bits = 0.
  - J: JAL; bit 0 = 0.
  - All others: 0.
- Illegal:
  - Condition: instr[1:0]!=2'b11, or opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - Effect: out_illegal=1, out_reg_we=0; no hazard check.
- Hazard. Stall when in_valid and any of:
  - uses_rs1 and busy[rs1_src]
  - uses_rs2 and busy[rs2_src]
  - writes_rd and busy[rd] (WAW; guarantees at most one pending writer per register)
- x0 is never busy.
- A busy bit cleared by wb_we this cycle still counts as busy for this cycle's stall decision: the regfile write lands at the clock edge, so the operand is read next cycle.
- in_ready = !rst && !flush && !stall && (!out_valid || out_ready).
- Accept (in_valid && in_ready):
  - ID/EX register loads all fields; out_valid=1 next cycle.
  - If writes_rd, busy[rd] set.
- Drain (out_valid && out_ready && no accept): out_valid=0.
- Hold (out_valid && !out_ready): all out_* stable.
- Busy update per cycle:
  - wb_we && wb_rd_src!=0 clears busy[wb_rd_src].
  - An accept sets busy[rd].
  - Same index in the same cycle: set wins.
- Latency: accept at edge N, out_valid at N+1; one instruction per cycle when there are no hazards.
- Flush (highest priority after rst):
  - out_valid=0 next cycle.
  - If out_valid && out_reg_we, busy[out_rd_src] cleared (unless wb sets it same cycle — not possible by WAW rule).
  - in_ready=0 this cycle.
  - Writebacks already past execute still clear their bits.
- rst mid-operation: all pending instructions dropped, busy cleared; wb_we during rst is ignored.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - When wb_we && wb_rd_src!=0 && wb_rd_src==rs1_src, the latched rs1 operand is wb_rd instead of rs1; same rule for rs2.
  - A busy bit being cleared by wb this cycle does not stall (RAW and WAW), saving one cycle.
- Undefined:
  - Operands come only from rs1/rs2.
  - Stall rule exactly as in Behaviour.

Test Plan:
- Reset: rst=1 two cycles -> out_valid=0, in_ready=0 during rst; after rst deassert in_ready=1.
- ADDI x5,x0,-3 (0xFFD00293) accepted, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFD, out_rd_src=5, out_reg_we=1, busy[5]=1.
- RAW: ADD x6,x5,x5 after the ADDI above, wb of x5 three cycles later:
  - Base: in_ready=0 until the cycle after wb_we, then accept with rs1=rs2=regfile value.
  - With ID_BYPASS_EN: accept in the wb cycle, out_rs1_val=out_rs2_val=wb_rd.
- Back-pressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_* unchanged; out_ready=1 -> next instruction loads the following cycle.
- Flush: ADDI x7 held in ID/EX, flush=1 -> out_valid=0 next cycle, busy[7]=0; subsequent ADD x8,x7,x0 accepted without stall.
- Illegal: instr 0x00000000 -> out_illegal=1, out_reg_we=0, no busy bit set; LUI x0 -> out_reg_we=0.
